// File: rtl/test_arb.sv
// test_arb: round-robin arbiter and sequencer for one shared 4-bit `test`
// transform unit. One of two requesters wins an operand handshake. The
// operand is driven onto the unit input and held for SETTLE cycles. The
// unit output is then captured and returned with the winner's ID over a
// valid/ready response channel.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/data/ready     requester 0 operand handshake
//   req1_valid/data/ready     requester 1 operand handshake
//   u_a                       registered drive to the shared unit input
//   u_b                       shared unit output
//   rsp_valid/id/data/ready   response handshake (captured u_b + owner ID)
//   busy                      high while an operation is in flight (EXEC/RESP)
module test_arb #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic [W-1:0] u_a,
  input  logic [W-1:0] u_b,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  input  logic         rsp_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The settle counter counts down to zero, so it is loaded with SETTLE-1.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   u_a_q, u_a_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           gnt0_s, gnt1_s;
  logic           idle_s;

  // Round-robin grant: on a tie the requester that did not win last time wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0_s = last_q;
      gnt1_s = ~last_q;
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
  end

  assign idle_s     = (state_q == IDLE);
  assign req0_ready = ~rst & idle_s & gnt0_s;
  assign req1_ready = ~rst & idle_s & gnt1_s;

  // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    u_a_d       = u_a_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (gnt0_s || gnt1_s) begin
          u_a_d    = gnt1_s ? req1_data : req0_data;
          rsp_id_d = gnt1_s;
          last_d   = gnt1_s;
          cnt_d    = CNT_LOAD;
          state_d  = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // u_a has been stable for SETTLE cycles; sample the unit now.
          rsp_data_d  = u_b;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 4'd0;
      u_a_q       <= {W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      u_a_q       <= u_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign u_a       = u_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = ~idle_s;

endmodule
